// File: rtl/arfs_pkg.sv
// Shared ARFS types, protocol constants and header byte offsets.
// Used by the header parser and the downstream flow-table stage.
package arfs_pkg;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [7:0]  proto;
    } arfs_key_t;

    typedef struct packed {
        logic        is_ipv4;
        logic        is_l4;
        logic        is_ctrl;
        arfs_key_t   key;
        logic [15:0] ctrl_qid;
        logic [7:0]  ctrl_op;
    } arfs_meta_t;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL5 = 8'h45;
    localparam logic [7:0]  PROTO_TCP     = 8'd6;
    localparam logic [7:0]  PROTO_UDP     = 8'd17;

    localparam int unsigned OFS_ETYPE   = 12;
    localparam int unsigned OFS_VER_IHL = 14;
    localparam int unsigned OFS_FRAG    = 20;
    localparam int unsigned OFS_PROTO   = 23;
    localparam int unsigned OFS_SRC_IP  = 26;
    localparam int unsigned OFS_DST_IP  = 30;
    localparam int unsigned OFS_SPORT   = 34;
    localparam int unsigned OFS_DPORT   = 36;
    localparam int unsigned OFS_QID     = 42;
    localparam int unsigned OFS_OP      = 44;

    // Byte idx of a beat; byte 0 is the first byte on the wire.
    function automatic logic [7:0] get_byte(input logic [511:0] d, input int unsigned idx);
        return d[idx*8 +: 8];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/arfs_axis_skid.sv
// Two-entry AXI-stream skid buffer with registered valid, ready and payload.
// Head register drives the output; the spare register absorbs one beat of backpressure.
module arfs_axis_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_payload,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_payload
);

    logic [W-1:0] head_r;
    logic [W-1:0] spare_r;
    logic [1:0]   count_r;
    logic [1:0]   count_next_s;
    logic         ready_r;
    logic         valid_r;
    logic         push_s;
    logic         pop_s;

    assign push_s    = s_valid && ready_r;
    assign pop_s     = valid_r && m_ready;
    assign s_ready   = ready_r;
    assign m_valid   = valid_r;
    assign m_payload = head_r;

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Storage and registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= '0;
            spare_r <= '0;
            count_r <= 2'd0;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            count_r <= count_next_s;
            ready_r <= (count_next_s < 2'd2);
            valid_r <= (count_next_s != 2'd0);
            // With two entries held, ready was low, so no push can coincide with the refill.
            if (push_s && ((count_r == 2'd0) || ((count_r == 2'd1) && pop_s))) begin
                head_r <= s_payload;
            end else if (pop_s && (count_r == 2'd2)) begin
                head_r <= spare_r;
            end else begin
                head_r <= head_r;
            end
            if (push_s && !pop_s && (count_r == 2'd1)) begin
                spare_r <= s_payload;
            end else begin
                spare_r <= spare_r;
            end
        end
    end

endmodule

// File: rtl/arfs_hdr_parser.sv
// ARFS C2H header parser: extracts the flow 5-tuple and control fields from the first beat
// and forwards every beat unchanged with that metadata as sideband through a skid buffer.
module arfs_hdr_parser
    import arfs_pkg::*;
#(
    parameter int unsigned DATA_W        = 512,
    parameter logic [15:0] CTRL_UDP_PORT = 16'hF2F2,
    parameter logic [15:0] MIN_PARSE_LEN = 16'd45
) (
    input  logic                  axis_aclk,
    input  logic                  axis_areset,
    input  logic                  s_axis_c2h_tvalid,
    input  logic [DATA_W-1:0]     s_axis_c2h_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_c2h_tkeep,
    input  logic                  s_axis_c2h_tlast,
    input  logic [15:0]           s_axis_c2h_tuser_size,
    output logic                  s_axis_c2h_tready,
    output logic                  m_axis_c2h_tvalid,
    output logic [DATA_W-1:0]     m_axis_c2h_tdata,
    output logic [DATA_W/8-1:0]   m_axis_c2h_tkeep,
    output logic                  m_axis_c2h_tlast,
    output logic [15:0]           m_axis_c2h_tuser_size,
    input  logic                  m_axis_c2h_tready,
    output logic                  m_meta_is_ipv4,
    output logic                  m_meta_is_l4,
    output logic                  m_meta_is_ctrl,
    output logic [103:0]          m_meta_key,
    output logic [15:0]           m_meta_ctrl_qid,
    output logic [7:0]            m_meta_ctrl_op,
    output logic [31:0]           stat_pkt_cnt,
    output logic [31:0]           stat_ctrl_cnt,
    output logic [31:0]           stat_drop_parse_cnt
);

    localparam int unsigned KEEP_W    = DATA_W / 8;
    localparam int unsigned PAYLOAD_W = DATA_W + KEEP_W + 1 + 16 + $bits(arfs_meta_t);

    logic                 in_pkt_r;
    arfs_meta_t           meta_hold_r;
    arfs_meta_t           parsed_s;
    arfs_meta_t           meta_push_s;
    arfs_meta_t           out_meta_s;
    logic                 accept_s;
    logic                 first_s;
    logic                 runt_s;
    logic [PAYLOAD_W-1:0] skid_in_s;
    logic [PAYLOAD_W-1:0] skid_out_s;
    logic [31:0]          pkt_cnt_r;
    logic [31:0]          ctrl_cnt_r;
    logic [31:0]          drop_cnt_r;

    logic [15:0] etype_s;
    logic [7:0]  ver_ihl_s;
    logic [7:0]  frag_hi_s;
    logic [7:0]  frag_lo_s;
    logic [7:0]  proto_s;
    logic [15:0] dport_s;
    logic        ipv4_s;
    logic        l4_s;
    logic        ctrl_s;

    assign accept_s = s_axis_c2h_tvalid && s_axis_c2h_tready;
    assign first_s  = !in_pkt_r;
    assign runt_s   = (s_axis_c2h_tuser_size < MIN_PARSE_LEN);

    // Header field extraction and classification of the current input beat.
    always_comb begin
        parsed_s  = '0;
        etype_s   = {get_byte(s_axis_c2h_tdata, OFS_ETYPE), get_byte(s_axis_c2h_tdata, OFS_ETYPE + 1)};
        ver_ihl_s = get_byte(s_axis_c2h_tdata, OFS_VER_IHL);
        frag_hi_s = get_byte(s_axis_c2h_tdata, OFS_FRAG);
        frag_lo_s = get_byte(s_axis_c2h_tdata, OFS_FRAG + 1);
        proto_s   = get_byte(s_axis_c2h_tdata, OFS_PROTO);
        dport_s   = {get_byte(s_axis_c2h_tdata, OFS_DPORT), get_byte(s_axis_c2h_tdata, OFS_DPORT + 1)};
        ipv4_s    = (etype_s == ETH_TYPE_IPV4) && (ver_ihl_s == IPV4_VER_IHL5);
        // MF is bit 5 of the high flags byte; the offset spans its low 5 bits and the next byte.
        l4_s      = ipv4_s && ((proto_s == PROTO_TCP) || (proto_s == PROTO_UDP))
                    && ((frag_hi_s & 8'h3F) == 8'h00) && (frag_lo_s == 8'h00);
        ctrl_s    = l4_s && (proto_s == PROTO_UDP) && (dport_s == CTRL_UDP_PORT);
        if (runt_s) begin
            parsed_s = '0;
        end else begin
            parsed_s.is_ipv4 = ipv4_s;
            parsed_s.is_l4   = l4_s;
            parsed_s.is_ctrl = ctrl_s;
            if (l4_s) begin
                parsed_s.key.src_ip   = {get_byte(s_axis_c2h_tdata, OFS_SRC_IP),
                                         get_byte(s_axis_c2h_tdata, OFS_SRC_IP + 1),
                                         get_byte(s_axis_c2h_tdata, OFS_SRC_IP + 2),
                                         get_byte(s_axis_c2h_tdata, OFS_SRC_IP + 3)};
                parsed_s.key.dst_ip   = {get_byte(s_axis_c2h_tdata, OFS_DST_IP),
                                         get_byte(s_axis_c2h_tdata, OFS_DST_IP + 1),
                                         get_byte(s_axis_c2h_tdata, OFS_DST_IP + 2),
                                         get_byte(s_axis_c2h_tdata, OFS_DST_IP + 3)};
                parsed_s.key.src_port = {get_byte(s_axis_c2h_tdata, OFS_SPORT),
                                         get_byte(s_axis_c2h_tdata, OFS_SPORT + 1)};
                parsed_s.key.dst_port = dport_s;
                parsed_s.key.proto    = proto_s;
            end else begin
                parsed_s.key = '0;
            end
            if (ctrl_s) begin
                parsed_s.ctrl_qid = {get_byte(s_axis_c2h_tdata, OFS_QID + 1),
                                     get_byte(s_axis_c2h_tdata, OFS_QID)};
                parsed_s.ctrl_op  = get_byte(s_axis_c2h_tdata, OFS_OP);
            end else begin
                parsed_s.ctrl_qid = 16'h0000;
                parsed_s.ctrl_op  = 8'h00;
            end
        end
    end

    assign meta_push_s = first_s ? parsed_s : meta_hold_r;
    assign skid_in_s   = {s_axis_c2h_tdata, s_axis_c2h_tkeep, s_axis_c2h_tlast,
                          s_axis_c2h_tuser_size, meta_push_s};

    // Packet boundary tracking and per-packet metadata hold.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            in_pkt_r    <= 1'b0;
            meta_hold_r <= '0;
        end else if (accept_s) begin
            in_pkt_r    <= !s_axis_c2h_tlast;
            meta_hold_r <= meta_push_s;
        end else begin
            in_pkt_r    <= in_pkt_r;
            meta_hold_r <= meta_hold_r;
        end
    end

    arfs_axis_skid #(.W(PAYLOAD_W)) u_skid (
        .clk       (axis_aclk),
        .rst       (axis_areset),
        .s_valid   (s_axis_c2h_tvalid),
        .s_ready   (s_axis_c2h_tready),
        .s_payload (skid_in_s),
        .m_valid   (m_axis_c2h_tvalid),
        .m_ready   (m_axis_c2h_tready),
        .m_payload (skid_out_s)
    );

    assign {m_axis_c2h_tdata, m_axis_c2h_tkeep, m_axis_c2h_tlast,
            m_axis_c2h_tuser_size, out_meta_s} = skid_out_s;

    assign m_meta_is_ipv4  = out_meta_s.is_ipv4;
    assign m_meta_is_l4    = out_meta_s.is_l4;
    assign m_meta_is_ctrl  = out_meta_s.is_ctrl;
    assign m_meta_key      = out_meta_s.key;
    assign m_meta_ctrl_qid = out_meta_s.ctrl_qid;
    assign m_meta_ctrl_op  = out_meta_s.ctrl_op;

    // Saturating statistics: forwarded packets, forwarded control packets, runt first beats.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            pkt_cnt_r  <= 32'd0;
            ctrl_cnt_r <= 32'd0;
            drop_cnt_r <= 32'd0;
        end else begin
            if (m_axis_c2h_tvalid && m_axis_c2h_tready && m_axis_c2h_tlast) begin
                pkt_cnt_r  <= sat_inc(pkt_cnt_r);
                ctrl_cnt_r <= out_meta_s.is_ctrl ? sat_inc(ctrl_cnt_r) : ctrl_cnt_r;
            end else begin
                pkt_cnt_r  <= pkt_cnt_r;
                ctrl_cnt_r <= ctrl_cnt_r;
            end
            if (accept_s && first_s && runt_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign stat_pkt_cnt        = pkt_cnt_r;
    assign stat_ctrl_cnt       = ctrl_cnt_r;
    assign stat_drop_parse_cnt = drop_cnt_r;

endmodule

// File: tb/tb_arfs_hdr_parser.sv
// Scoreboard bench for arfs_hdr_parser: directed packets push expected beats into a queue,
// a negedge monitor pops and compares every forwarded beat.
module tb_arfs_hdr_parser;
    import arfs_pkg::*;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic [15:0]  size;
        arfs_meta_t   meta;
    } beat_t;

    logic         clk;
    logic         rst;
    logic         s_tvalid;
    logic [511:0] s_tdata;
    logic [63:0]  s_tkeep;
    logic         s_tlast;
    logic [15:0]  s_tsize;
    logic         s_tready;
    logic         m_tvalid;
    logic [511:0] m_tdata;
    logic [63:0]  m_tkeep;
    logic         m_tlast;
    logic [15:0]  m_tsize;
    logic         m_tready;
    logic         is_ipv4, is_l4, is_ctrl;
    logic [103:0] key;
    logic [15:0]  qid;
    logic [7:0]   op;
    logic [31:0]  pkt_cnt, ctrl_cnt, drop_cnt;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    last_cycles;
    logic  occ_chk = 1'b0;

    arfs_hdr_parser dut (
        .axis_aclk             (clk),
        .axis_areset           (rst),
        .s_axis_c2h_tvalid     (s_tvalid),
        .s_axis_c2h_tdata      (s_tdata),
        .s_axis_c2h_tkeep      (s_tkeep),
        .s_axis_c2h_tlast      (s_tlast),
        .s_axis_c2h_tuser_size (s_tsize),
        .s_axis_c2h_tready     (s_tready),
        .m_axis_c2h_tvalid     (m_tvalid),
        .m_axis_c2h_tdata      (m_tdata),
        .m_axis_c2h_tkeep      (m_tkeep),
        .m_axis_c2h_tlast      (m_tlast),
        .m_axis_c2h_tuser_size (m_tsize),
        .m_axis_c2h_tready     (m_tready),
        .m_meta_is_ipv4        (is_ipv4),
        .m_meta_is_l4          (is_l4),
        .m_meta_is_ctrl        (is_ctrl),
        .m_meta_key            (key),
        .m_meta_ctrl_qid       (qid),
        .m_meta_ctrl_op        (op),
        .stat_pkt_cnt          (pkt_cnt),
        .stat_ctrl_cnt         (ctrl_cnt),
        .stat_drop_parse_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] mk_hdr(input logic [15:0] etype, input logic [7:0] ver_ihl,
                                            input logic [7:0] flags, input logic [7:0] proto,
                                            input logic [31:0] sip, input logic [31:0] dip,
                                            input logic [15:0] sport, input logic [15:0] dport,
                                            input logic [7:0] b42, input logic [7:0] b43,
                                            input logic [7:0] b44, input logic [7:0] tag);
        logic [511:0] d;
        d = '0;
        d[12*8 +: 8] = etype[15:8];  d[13*8 +: 8] = etype[7:0];
        d[14*8 +: 8] = ver_ihl;      d[20*8 +: 8] = flags;
        d[23*8 +: 8] = proto;
        d[26*8 +: 8] = sip[31:24];   d[27*8 +: 8] = sip[23:16];
        d[28*8 +: 8] = sip[15:8];    d[29*8 +: 8] = sip[7:0];
        d[30*8 +: 8] = dip[31:24];   d[31*8 +: 8] = dip[23:16];
        d[32*8 +: 8] = dip[15:8];    d[33*8 +: 8] = dip[7:0];
        d[34*8 +: 8] = sport[15:8];  d[35*8 +: 8] = sport[7:0];
        d[36*8 +: 8] = dport[15:8];  d[37*8 +: 8] = dport[7:0];
        d[42*8 +: 8] = b42; d[43*8 +: 8] = b43; d[44*8 +: 8] = b44;
        d[60*8 +: 8] = tag;
        return d;
    endfunction

    function automatic arfs_meta_t mk_meta(input logic v4, input logic l4, input logic ct,
                                           input logic [31:0] sip, input logic [31:0] dip,
                                           input logic [15:0] sport, input logic [15:0] dport,
                                           input logic [7:0] proto, input logic [15:0] q,
                                           input logic [7:0] o);
        arfs_meta_t m;
        m = {v4, l4, ct, sip, dip, sport, dport, proto, q, o};
        return m;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drives one beat and waits for the handshake; records the expected output beat on accept.
    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                             input logic [15:0] sz, input arfs_meta_t m);
        logic ok;
        beat_t b;
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l; s_tsize = sz;
        last_cycles = 0;
        forever begin
            ok = s_tready;
            @(posedge clk); #1;
            last_cycles++;
            if (ok) break;
            if (last_cycles >= 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout actual=no_tready required=accept_within_200");
                break;
            end
        end
        if (ok) begin
            b = '{data: d, keep: k, last: l, size: sz, meta: m};
            exp_q.push_back(b);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: occupancy vs. tready, and in-order comparison of each forwarded beat.
    always @(negedge clk) begin
        beat_t e;
        arfs_meta_t am;
        if (!rst) begin
            if (occ_chk) begin
                checks++;
                if (s_tready !== (exp_q.size() < 2)) begin
                    errors++;
                    $display("FAIL tready_occ actual=%0b required=%0b", s_tready, exp_q.size() < 2);
                end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", m_tdata[511:448]);
                end else begin
                    e  = exp_q.pop_front();
                    am = {is_ipv4, is_l4, is_ctrl, key, qid, op};
                    if ({m_tdata, m_tkeep, m_tlast, m_tsize} !== {e.data, e.keep, e.last, e.size}) begin
                        errors++;
                        $display("FAIL beat_data actual=%0h required=%0h",
                                 {m_tdata, m_tkeep, m_tlast, m_tsize}, {e.data, e.keep, e.last, e.size});
                    end
                    checks++;
                    if (am !== e.meta) begin
                        errors++;
                        $display("FAIL beat_meta actual=%0h required=%0h", am, e.meta);
                    end
                end
            end
        end
    end

    localparam logic [63:0] KF = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        logic [511:0] hdr_ctrl, hdr_t2, hdr_vlan, hdr_mf, hdr_ihl6, d;
        arfs_meta_t   meta_ctrl, meta_t2, meta_mf;
        int           tot;

        hdr_ctrl = mk_hdr(16'h0800, 8'h45, 8'h00, 8'h11, 32'h6F6F_6F6F, 32'hDEDE_DEDE,
                          16'h04D2, 16'hF2F2, 8'hFA, 8'h00, 8'h01, 8'h01);
        hdr_t2   = mk_hdr(16'h0800, 8'h45, 8'h00, 8'h11, 32'h6F6F_6F6F, 32'hDEDE_DEDE,
                          16'h04D2, 16'h1234, 8'hFA, 8'h00, 8'h01, 8'h02);
        hdr_vlan = mk_hdr(16'h8100, 8'h45, 8'h00, 8'h11, 32'h6F6F_6F6F, 32'hDEDE_DEDE,
                          16'h04D2, 16'hF2F2, 8'hFA, 8'h00, 8'h01, 8'h03);
        hdr_mf   = mk_hdr(16'h0800, 8'h45, 8'h20, 8'h11, 32'h0A00_0001, 32'h0A00_0002,
                          16'h1111, 16'hF2F2, 8'h05, 8'h00, 8'h02, 8'h05);
        hdr_ihl6 = mk_hdr(16'h0800, 8'h46, 8'h00, 8'h06, 32'h0A00_0001, 32'h0A00_0002,
                          16'h1111, 16'h2222, 8'h00, 8'h00, 8'h00, 8'h06);
        meta_ctrl = mk_meta(1'b1, 1'b1, 1'b1, 32'h6F6F_6F6F, 32'hDEDE_DEDE, 16'h04D2, 16'hF2F2,
                            8'h11, 16'h00FA, 8'h01);
        meta_t2   = mk_meta(1'b1, 1'b1, 1'b0, 32'h6F6F_6F6F, 32'hDEDE_DEDE, 16'h04D2, 16'h1234,
                            8'h11, 16'h0000, 8'h00);
        meta_mf   = mk_meta(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 16'h0, 8'h0, 16'h0, 8'h0);

        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        s_tsize = 16'd0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready", s_tready, 1'b0);
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_stats", {pkt_cnt, ctrl_cnt, drop_cnt}, 96'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("tready_after_rst", s_tready, 1'b1);

        // 1: control packet
        send_beat(hdr_ctrl, KF, 1'b1, 16'd128, meta_ctrl);
        drain();
        check("t1_pkt_cnt", pkt_cnt, 32'd1);
        check("t1_ctrl_cnt", ctrl_cnt, 32'd1);

        // 2: same header to a non-control port
        send_beat(hdr_t2, KF, 1'b1, 16'd128, meta_t2);
        drain();
        check("t2_ctrl_cnt", ctrl_cnt, 32'd1);

        // 3: VLAN 2-beat; second beat carries a control header that must not be reparsed
        send_beat(hdr_vlan, KF, 1'b0, 16'd100, '0);
        send_beat(hdr_ctrl, 64'h0000_000F_FFFF_FFFF, 1'b1, 16'd100, '0);
        drain();
        check("t3_pkt_cnt", pkt_cnt, 32'd3);

        // 4a: full throughput with m_tready held high
        occ_chk = 1'b1;
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            d = mk_hdr(16'h0000, 8'h00, 8'h00, 8'h00, 32'h0, 32'h0, 16'h0, 16'h0,
                       8'h0, 8'h0, 8'h0, 8'h40 + 8'(i));
            send_beat(d, KF, 1'b1, 16'd64, '0);
            tot += last_cycles;
        end
        check("t4_throughput_cycles", 32'(tot), 32'd4);
        // 4b: m_tready toggling every cycle
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    d = mk_hdr(16'h0000, 8'h00, 8'h00, 8'h00, 32'h0, 32'h0, 16'h0, 16'h0,
                               8'h0, 8'h0, 8'h0, 8'h50 + 8'(i));
                    send_beat(d, KF, 1'b1, 16'd64, '0);
                end
            end
            begin
                repeat (12) begin
                    @(posedge clk); #1 m_tready = ~m_tready;
                end
            end
        join
        // 4c: m_tready held low for 5 cycles
        m_tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    d = mk_hdr(16'h0000, 8'h00, 8'h00, 8'h00, 32'h0, 32'h0, 16'h0, 16'h0,
                               8'h0, 8'h0, 8'h0, 8'h60 + 8'(i));
                    send_beat(d, KF, 1'b1, 16'd64, '0);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1 m_tready = 1'b1;
            end
        join
        drain();
        occ_chk = 1'b0;
        check("t4_pkt_cnt", pkt_cnt, 32'd14);

        // 5: fragment, IHL=6, runt
        send_beat(hdr_mf, KF, 1'b1, 16'd90, meta_mf);
        send_beat(hdr_ihl6, KF, 1'b1, 16'd90, '0);
        send_beat(hdr_ctrl, KF, 1'b1, 16'd40, '0);
        drain();
        check("t5_drop_cnt", drop_cnt, 32'd1);
        check("t5_pkt_cnt", pkt_cnt, 32'd17);
        check("t5_ctrl_cnt", ctrl_cnt, 32'd1);

        // 6a: counter saturation
        force dut.pkt_cnt_r = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        release dut.pkt_cnt_r;
        send_beat(hdr_t2, KF, 1'b1, 16'd128, meta_t2);
        send_beat(hdr_t2, KF, 1'b1, 16'd128, meta_t2);
        drain();
        check("t6_pkt_cnt_sat", pkt_cnt, 32'hFFFF_FFFF);

        // 6b: reset after beat 1 of a 3-beat packet
        m_tready = 1'b0;
        send_beat(hdr_ctrl, KF, 1'b0, 16'd180, meta_ctrl);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tvalid", m_tvalid, 1'b0);
        check("mid_rst_tready", s_tready, 1'b0);
        check("mid_rst_outputs", {m_tdata[127:0], key, is_ctrl, qid, op}, '0);
        check("mid_rst_stats", {pkt_cnt, ctrl_cnt, drop_cnt}, 96'd0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        m_tready = 1'b1;
        send_beat(hdr_ctrl, KF, 1'b1, 16'd128, meta_ctrl);
        drain();
        check("post_rst_pkt_cnt", pkt_cnt, 32'd1);
        check("post_rst_ctrl_cnt", ctrl_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
